adc_rate_seq_ctrl: RTL and testbench
====================================

Name: adc_rate_seq_ctrl

Overview:
- Bring-up and supervision sequencer for the ADC 160→320 MS/s rate changer and its DCM. Runs in the clkin160 domain.
- Pulses dcm_reset, waits for a stable synchronized dcm_locked, then enables the rate-changer datapath. After a flush interval it declares output valid.
- Detects lock loss and re-runs the bring-up with a bounded retry count. Latches a fault when retries are exhausted.

Parameters:
- RST_CYCLES, 16, cycles dcm_reset is held high per attempt (min 1).
- LOCK_TIMEOUT, 4096, cycles to wait for synchronized lock before the attempt fails.
- SETTLE_CYCLES, 64, cycles lock must stay continuously high before the datapath is enabled.
- FLUSH_CYCLES, 4, cycles between dp_enable rising and out_valid rising (pipeline flush).
- MAX_RETRY, 3, failed attempts allowed before FAULT.

Ports:
- clkin160  in  1  system clock, 160 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; 1 requests operation, 0 returns the block to IDLE.
- dcm_locked  in  1  DCM lock, asynchronous to clkin160; internally 2-flop synchronized.
- fault_clr  in  1  single-cycle pulse; clears FAULT.
- dcm_reset  out  1  DCM reset, active high, registered.
- dp_enable  out  1  rate-changer datapath enable, registered.
- out_valid  out  1  i_out/q_out stream valid, registered.
- busy  out  1  high in every state except IDLE, RUN and FAULT.
- fault  out  1  high in FAULT.
- retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts since start.
- state  out  3  encoded state: IDLE=0, DCM_RST=1, WAIT_LOCK=2, SETTLE=3, FLUSH=4, RUN=5, FAULT=6.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; dcm_reset=1; dp_enable=0; out_valid=0; fault=0; retry_cnt=0; synchronizer flops=0.
- All outputs are registered and reflect the current state. lock_s is the synchronized lock (2 cycles latency from dcm_locked).
- IDLE:
  - Outputs: dcm_reset=1, dp_enable=0, out_valid=0.
  - start=1 → DCM_RST; the cycle counter loads RST_CYCLES-1 and retry_cnt clears to 0.
- DCM_RST:
  - dcm_reset=1, held for exactly RST_CYCLES cycles.
  - Then → WAIT_LOCK; dcm_reset goes 0 in the first WAIT_LOCK cycle; counter loads LOCK_TIMEOUT-1.
- WAIT_LOCK:
  - lock_s=1 → SETTLE; counter loads SETTLE_CYCLES-1.
  - Counter reaches 0 with lock_s=0 → attempt failure.
- SETTLE:
  - lock_s must stay 1 for SETTLE_CYCLES consecutive cycles, then → FLUSH; dp_enable=1; counter loads FLUSH_CYCLES-1.
  - lock_s=0 at any point → attempt failure.
- FLUSH:
  - dp_enable=1, out_valid=0.
  - After FLUSH_CYCLES cycles → RUN; out_valid=1.
  - lock_s=0 → attempt failure.
- RUN:
  - dp_enable=1, out_valid=1; holds indefinitely.
  - lock_s=0 → attempt failure. out_valid and dp_enable drop on the next edge, together with dcm_reset rising.
- Attempt failure:
  - If retry_cnt < MAX_RETRY: retry_cnt+1, → DCM_RST.
  - Else → FAULT.
  - A successful reach of RUN does not clear retry_cnt; only a new start from IDLE clears it.
- FAULT:
  - dcm_reset=1, dp_enable=0, out_valid=0, fault=1.
  - fault_clr=1 → IDLE; fault=0 next cycle. retry_cnt is retained until the next start.
- start=0 in any state except FAULT → IDLE next cycle. Outputs take IDLE values and the counter is cleared. start=0 has no effect in FAULT; only fault_clr exits.
- Simultaneous events, priority:
  - reset_n > fault_clr (FAULT only) > start=0 > lock loss > counter expiry.
  - Lock loss on the same cycle the SETTLE or FLUSH counter expires is a failure, not an advance.
- Counter: width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, FLUSH_CYCLES)); down-counts; never wraps (a 0 value always triggers a transition).
- A glitch on dcm_locked shorter than one clkin160 period may be missed. This is acceptable; one lasting 2 or more cycles must be detected.

Test Plan:
- Nominal bring-up, defaults, lock rising 100 cycles after dcm_reset falls:
  - dcm_reset high exactly 16 cycles after start.
  - dp_enable rises 2+64 cycles after dcm_locked rises.
  - out_valid rises 4 cycles after dp_enable.
  - retry_cnt=0, busy=0 in RUN.
- Lock never asserts: 4 attempts of 16+4096 cycles each; retry_cnt steps 1,2,3; then FAULT (fault=1, dcm_reset=1). fault_clr pulse → IDLE, fault=0.
- Lock drops 10 cycles into SETTLE, then relocks: returns to DCM_RST with retry_cnt=1, then completes to RUN; out_valid never rose before RUN.
- Lock loss in RUN for 3 cycles: out_valid and dp_enable fall within 3 cycles of the dcm_locked fall; re-sequence reaches RUN with retry_cnt=1.
- start deasserted mid-WAIT_LOCK: IDLE next cycle, dcm_reset=1; re-assert start gives a fresh sequence with retry_cnt=0.
- reset_n asserted asynchronously mid-RUN (off clock edge): all outputs go to reset values immediately without waiting for a clock edge; state=0.

Source files
------------

// File: rtl/adc_rate_seq_ctrl.sv
// Bring-up and supervision sequencer for the ADC 160->320 MS/s rate changer and its DCM.
// Pulses the DCM reset, qualifies a synchronized lock, enables the datapath and retries on lock loss.
`timescale 1ns/1ps
module adc_rate_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64,
  parameter int FLUSH_CYCLES  = 4,
  parameter int MAX_RETRY     = 3,
  localparam int RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clkin160,
  input  logic               reset_n,
  input  logic               start,
  input  logic               dcm_locked,
  input  logic               fault_clr,
  output logic               dcm_reset,
  output logic               dp_enable,
  output logic               out_valid,
  output logic               busy,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam int CNT_M1  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_M2  = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > CNT_M2) ? CNT_M1 : CNT_M2;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DCM_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_FLUSH     = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_meta_q, lock_s_q;
  logic               dcm_reset_q, dp_enable_q, out_valid_q, busy_q, fault_q;
  logic               fail;

  // Two-flop synchronizer: dcm_locked is asynchronous to clkin160.
  always_ff @(posedge clkin160 or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= dcm_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Priority: fault_clr (FAULT only) > start=0 > lock loss > counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;
    if (state_q == S_FAULT) begin
      if (fault_clr) begin
        state_d = S_IDLE;
      end
    end else if (!start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DCM_RST;
          cnt_d   = RST_LOAD;
          retry_d = '0;
        end
        S_DCM_RST: begin
          if (cnt_q == '0) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else if (cnt_q == '0) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (!lock_s_q) begin
            fail = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_FLUSH: begin
          if (!lock_s_q) begin
            fail = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            fail = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      // A failed attempt either restarts the DCM reset pulse or gives up.
      if (fail) begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = S_DCM_RST;
          cnt_d   = RST_LOAD;
        end else begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clkin160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      dcm_reset_q <= 1'b1;
      dp_enable_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_reset_q <= (state_d == S_IDLE) || (state_d == S_DCM_RST) || (state_d == S_FAULT);
      dp_enable_q <= (state_d == S_FLUSH) || (state_d == S_RUN);
      out_valid_q <= (state_d == S_RUN);
      busy_q      <= (state_d == S_DCM_RST) || (state_d == S_WAIT_LOCK) ||
                     (state_d == S_SETTLE) || (state_d == S_FLUSH);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign dcm_reset = dcm_reset_q;
  assign dp_enable = dp_enable_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_adc_rate_seq_ctrl.sv
// Bench for adc_rate_seq_ctrl: directed bring-up scenarios plus randomized lock/start/fault_clr
// traffic, all compared cycle by cycle against an elapsed-time reference model.
`timescale 1ns/1ps
module tb_adc_rate_seq_ctrl;

  localparam int RST_CYCLES    = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int SETTLE_CYCLES = 64;
  localparam int FLUSH_CYCLES  = 4;
  localparam int MAX_RETRY     = 3;

  localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_SETTLE = 3, P_FLUSH = 4, P_RUN = 5, P_FAULT = 6;
  localparam int SEL_DCMRST = 0, SEL_DP = 1, SEL_OV = 2, SEL_STATE = 3;

  logic       clk = 1'b0;
  logic       reset_n, start, dcm_locked, fault_clr;
  logic       dcm_reset, dp_enable, out_valid, busy, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  int m_ph, m_t, m_retry;
  bit lock_q[$];
  bit ov_early;
  int retry_hist[$];
  int last_retry;

  adc_rate_seq_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
    .FLUSH_CYCLES(FLUSH_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clkin160(clk), .reset_n(reset_n), .start(start), .dcm_locked(dcm_locked),
    .fault_clr(fault_clr), .dcm_reset(dcm_reset), .dp_enable(dp_enable),
    .out_valid(out_valid), .busy(busy), .fault(fault), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE;
    m_t = 0;
    m_retry = 0;
    lock_q.delete();
    lock_q.push_back(1'b0);
    lock_q.push_back(1'b0);
  endtask

  // One clock edge of the reference: lock is seen two edges after it is sampled,
  // and each phase ends once its elapsed cycle count reaches the configured length.
  task automatic model_step();
    bit ls;
    bit failed;
    int nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ls = lock_q[0];
    lock_q.push_back(dcm_locked);
    void'(lock_q.pop_front());
    nxt = m_ph;
    failed = 1'b0;
    if (m_ph == P_FAULT) begin
      if (fault_clr) nxt = P_IDLE;
    end else if (!start) begin
      nxt = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE:   begin nxt = P_RST; m_retry = 0; end
        P_RST:    if (m_t + 1 >= RST_CYCLES) nxt = P_WAIT;
        P_WAIT:   if (ls) nxt = P_SETTLE; else if (m_t + 1 >= LOCK_TIMEOUT) failed = 1'b1;
        P_SETTLE: if (!ls) failed = 1'b1; else if (m_t + 1 >= SETTLE_CYCLES) nxt = P_FLUSH;
        P_FLUSH:  if (!ls) failed = 1'b1; else if (m_t + 1 >= FLUSH_CYCLES) nxt = P_RUN;
        P_RUN:    if (!ls) failed = 1'b1;
        default:  nxt = P_IDLE;
      endcase
      if (failed) begin
        if (m_retry < MAX_RETRY) begin
          m_retry++;
          nxt = P_RST;
        end else begin
          nxt = P_FAULT;
        end
      end
    end
    m_t = (nxt != m_ph) ? 0 : m_t + 1;
    m_ph = nxt;
  endtask

  function automatic logic [9:0] model_vec();
    logic r, d, v, b, f;
    r = (m_ph == P_IDLE) || (m_ph == P_RST) || (m_ph == P_FAULT);
    d = (m_ph == P_FLUSH) || (m_ph == P_RUN);
    v = (m_ph == P_RUN);
    b = (m_ph >= P_RST) && (m_ph <= P_FLUSH);
    f = (m_ph == P_FAULT);
    return {3'(m_ph), r, d, v, b, f, 2'(m_retry)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {state, dcm_reset, dp_enable, out_valid, busy, fault, retry_cnt};
  endfunction

  function automatic logic [2:0] probe(input int sel);
    case (sel)
      SEL_DCMRST: return {2'b00, dcm_reset};
      SEL_DP:     return {2'b00, dp_enable};
      SEL_OV:     return {2'b00, out_valid};
      default:    return state;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("lockstep", 32'(dut_vec()), 32'(model_vec()));
    if (out_valid && state != 3'(P_RUN)) ov_early = 1'b1;
    if (int'(retry_cnt) != last_retry) begin
      last_retry = int'(retry_cnt);
      retry_hist.push_back(last_retry);
    end
  endtask

  task automatic count_until(input string tag, input int sel, input logic [2:0] val,
                             input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (probe(sel) !== val && n < budget);
    check(tag, 32'(probe(sel)), 32'(val));
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; dcm_locked = 1'b0; fault_clr = 1'b0;
    ov_early = 1'b0; last_retry = 0;
    model_reset();
    #23;
    check("reset_vec", 32'(dut_vec()), 32'(model_vec()));
    check("reset_state", 32'(state), 0);
    reset_n = 1'b1;
    repeat (3) cyc();

    // Nominal bring-up; lock arrives 100 cycles after dcm_reset falls.
    start = 1'b1;
    count_until("s1_rst_entry", SEL_STATE, 3'(P_RST), 4, n);
    check("s1_rst_entry_lat", n, 1);
    count_until("s1_dcm_reset_fall", SEL_DCMRST, 3'd0, 64, n);
    check("s1_dcm_reset_width", n, RST_CYCLES);
    repeat (100) cyc();
    dcm_locked = 1'b1;
    cyc();
    count_until("s1_dp_rise", SEL_DP, 3'd1, 200, n);
    check("s1_dp_enable_lat", n, 2 + SETTLE_CYCLES);
    count_until("s1_ov_rise", SEL_OV, 3'd1, 20, n);
    check("s1_out_valid_lat", n, FLUSH_CYCLES);
    check("s1_run_state", 32'(state), P_RUN);
    check("s1_retry", 32'(retry_cnt), 0);
    check("s1_busy", 32'(busy), 0);
    repeat (20) cyc();
    check("s1_run_hold", 32'(state), P_RUN);

    // Lock lost in RUN for 3 cycles.
    dcm_locked = 1'b0;
    count_until("s4_ov_fall", SEL_OV, 3'd0, 10, n);
    check("s4_ov_fall_lat", n, 3);
    check("s4_dp_fall", 32'(dp_enable), 0);
    check("s4_dcm_reset_rise", 32'(dcm_reset), 1);
    check("s4_retry", 32'(retry_cnt), 1);
    dcm_locked = 1'b1;
    count_until("s4_rerun", SEL_STATE, 3'(P_RUN), 300, n);
    check("s4_rerun_retry", 32'(retry_cnt), 1);

    // start dropped from RUN, then mid-WAIT_LOCK.
    start = 1'b0;
    cyc();
    check("s5_idle_from_run", 32'(state), P_IDLE);
    check("s5_retry_kept", 32'(retry_cnt), 1);
    dcm_locked = 1'b0;
    start = 1'b1;
    count_until("s5_wait", SEL_STATE, 3'(P_WAIT), 40, n);
    check("s5_wait_lat", n, 1 + RST_CYCLES);
    check("s5_retry_clear", 32'(retry_cnt), 0);
    repeat (50) cyc();
    start = 1'b0;
    cyc();
    check("s5_idle", 32'(state), P_IDLE);
    check("s5_dcm_reset", 32'(dcm_reset), 1);
    check("s5_busy", 32'(busy), 0);

    // Lock drops 10 cycles into SETTLE, then relocks.
    start = 1'b1;
    ov_early = 1'b0;
    count_until("s3_wait", SEL_DCMRST, 3'd0, 40, n);
    dcm_locked = 1'b1;
    count_until("s3_settle", SEL_STATE, 3'(P_SETTLE), 10, n);
    check("s3_settle_lat", n, 3);
    repeat (10) cyc();
    dcm_locked = 1'b0;
    repeat (3) cyc();
    check("s3_fail_state", 32'(state), P_RST);
    check("s3_fail_retry", 32'(retry_cnt), 1);
    dcm_locked = 1'b1;
    count_until("s3_run", SEL_STATE, 3'(P_RUN), 300, n);
    check("s3_run_retry", 32'(retry_cnt), 1);
    check("s3_ov_early", 32'(ov_early), 0);

    // Asynchronous reset between clock edges while in RUN.
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("s6_async_vec", 32'(dut_vec()), 32'(model_vec()));
    check("s6_async_state", 32'(state), P_IDLE);
    check("s6_async_ov", 32'(out_valid), 0);
    #2;
    reset_n = 1'b1;
    cyc();

    // Lock never asserts: four full attempts, then FAULT.
    dcm_locked = 1'b0;
    start = 1'b0;
    cyc();
    retry_hist.delete();
    last_retry = int'(retry_cnt);
    start = 1'b1;
    count_until("s2_fault", SEL_STATE, 3'(P_FAULT), 4 * (RST_CYCLES + LOCK_TIMEOUT) + 20, n);
    check("s2_fault_lat", n, 1 + 4 * (RST_CYCLES + LOCK_TIMEOUT));
    check("s2_retry_steps", retry_hist.size(), 3);
    for (int i = 0; i < retry_hist.size() && i < 3; i++) check("s2_retry_step", retry_hist[i], i + 1);
    check("s2_fault_flag", 32'(fault), 1);
    check("s2_fault_dcm_reset", 32'(dcm_reset), 1);
    check("s2_fault_busy", 32'(busy), 0);
    start = 1'b0;
    repeat (5) cyc();
    check("s2_fault_hold", 32'(state), P_FAULT);
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    check("s2_clr_state", 32'(state), P_IDLE);
    check("s2_clr_fault", 32'(fault), 0);
    check("s2_clr_retry_kept", 32'(retry_cnt), 3);

    // Randomized lock, start and fault_clr traffic.
    start = 1'b1;
    for (int i = 0; i < 160; i++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        start = ~start;
      end else if (r < 14) begin
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
      end else begin
        dcm_locked = ($urandom_range(0, 3) != 0);
      end
      len = int'($urandom_range(1, 120));
      repeat (len) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
